tagged_update_sched: RTL and testbench

TAGGED_UPDATE_SCHED -- requirements
Module: tagged_update_sched

---
 rtl/tagged_update_sched_if.sv | 44 ++++
 rtl/tagged_update_sched.sv | 88 ++++++++
 tb/tb_tagged_update_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tagged_update_sched_if.sv
// tagged_update_sched_if: update, table-read and table-write signals of the tagged PHT update scheduler
// Ports (slave = scheduler side):
//   upd_*   commit-side update request; ready is high in every non-reset cycle
//   query_busy_i  table read port is taken by the frontend this cycle
//   rd_*    sweep read request/index out, read data in (valid the cycle after rd_req_o)
//   wr_*    registered table write port
//   sweep_active_o  an aging sweep is in progress
interface tagged_update_sched_if #(
  parameter int IW = 11,
  parameter int TAG_W = 12,
  parameter int CTR_W = 3,
  parameter int USEFUL_W = 2
);
  logic                upd_valid_i;
  logic                upd_ready_o;
  logic [IW-1:0]       upd_index_i;
  logic [TAG_W-1:0]    upd_tag_i;
  logic [CTR_W-1:0]    upd_ctr_i;
  logic [USEFUL_W-1:0] upd_useful_i;
  logic                query_busy_i;
  logic                rd_req_o;
  logic [IW-1:0]       rd_index_o;
  logic [TAG_W-1:0]    rd_tag_i;
  logic [CTR_W-1:0]    rd_ctr_i;
  logic [USEFUL_W-1:0] rd_useful_i;
  logic                wr_valid_o;
  logic [IW-1:0]       wr_index_o;
  logic [TAG_W-1:0]    wr_tag_o;
  logic [CTR_W-1:0]    wr_ctr_o;
  logic [USEFUL_W-1:0] wr_useful_o;
  logic                sweep_active_o;
  modport slave (
    input  upd_valid_i, upd_index_i, upd_tag_i, upd_ctr_i, upd_useful_i, query_busy_i,
    input  rd_tag_i, rd_ctr_i, rd_useful_i,
    output upd_ready_o, rd_req_o, rd_index_o,
    output wr_valid_o, wr_index_o, wr_tag_o, wr_ctr_o, wr_useful_o, sweep_active_o
  );
  modport master (
    output upd_valid_i, upd_index_i, upd_tag_i, upd_ctr_i, upd_useful_i, query_busy_i,
    output rd_tag_i, rd_ctr_i, rd_useful_i,
    input  upd_ready_o, rd_req_o, rd_index_o,
    input  wr_valid_o, wr_index_o, wr_tag_o, wr_ctr_o, wr_useful_o, sweep_active_o
  );
endinterface

// File: rtl/tagged_update_sched.sv
// tagged_update_sched: shares one PHT write port between commit updates and a periodic useful-bit aging sweep
// Ports:
//   clk  sole clock
//   rst  synchronous active-high reset
//   bus  tagged_update_sched_if.slave (update request, sweep read port, registered write port, sweep status)
module tagged_update_sched #(
  parameter int PHT_DEPTH = 2048,
  parameter int PHT_TAG_WIDTH = 12,
  parameter int PHT_CTR_WIDTH = 3,
  parameter int PHT_USEFUL_WIDTH = 2,
  parameter int AGE_PERIOD = 1024
) (
  input logic clk,
  input logic rst,
  tagged_update_sched_if.slave bus
);
  localparam int IW = $clog2(PHT_DEPTH);
  localparam int AW = $clog2(AGE_PERIOD) + 1;
  typedef enum logic [1:0] {IDLE, SW_RD, SW_WAIT, SW_WR} state_t;
  state_t                      state;
  logic [AW-1:0]               age_cnt;
  logic [IW-1:0]               sw_idx;
  logic                        drop;
  logic [PHT_TAG_WIDTH-1:0]    hold_tag;
  logic [PHT_CTR_WIDTH-1:0]    hold_ctr;
  logic [PHT_USEFUL_WIDTH-1:0] hold_useful;
  logic                        acc;
  logic                        hz;
  logic                        leave;
  logic                        sw_wr;
  assign bus.upd_ready_o = !rst;
  assign acc = bus.upd_valid_i && bus.upd_ready_o;
  assign bus.rd_req_o = state == SW_RD && !bus.query_busy_i;
  assign bus.rd_index_o = sw_idx;
  assign bus.sweep_active_o = state != IDLE;
  // an update to the entry being aged makes the held copy stale once its read has been issued
  assign hz = acc && bus.upd_index_i == sw_idx && (bus.rd_req_o || state == SW_WAIT || state == SW_WR);
  // SW_WR is left when there is nothing to write, or when the write port is free this cycle
  assign leave = state == SW_WR && (drop || hold_useful == '0 || !acc);
  assign sw_wr = leave && !drop && hold_useful != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      age_cnt <= '0;
      sw_idx <= '0;
      drop <= 1'b0;
      bus.wr_valid_o <= 1'b0;
    end else begin
      bus.wr_valid_o <= acc || sw_wr;
      if (acc) begin
        bus.wr_index_o <= bus.upd_index_i;
        bus.wr_tag_o <= bus.upd_tag_i;
        bus.wr_ctr_o <= bus.upd_ctr_i;
        bus.wr_useful_o <= bus.upd_useful_i;
      end else if (sw_wr) begin
        bus.wr_index_o <= sw_idx;
        bus.wr_tag_o <= hold_tag;
        bus.wr_ctr_o <= hold_ctr;
        bus.wr_useful_o <= hold_useful - 1'b1;
      end
      drop <= leave ? 1'b0 : drop || hz;
      case (state)
        IDLE: if (acc) begin
          if (age_cnt == AW'(AGE_PERIOD - 1)) begin
            age_cnt <= '0;
            sw_idx <= '0;
            drop <= 1'b0;
            state <= SW_RD;
          end else begin
            age_cnt <= age_cnt + 1'b1;
          end
        end
        SW_RD: if (bus.rd_req_o) state <= SW_WAIT;
        SW_WAIT: begin
          hold_tag <= bus.rd_tag_i;
          hold_ctr <= bus.rd_ctr_i;
          hold_useful <= bus.rd_useful_i;
          state <= SW_WR;
        end
        SW_WR: if (leave) begin
          state <= sw_idx == IW'(PHT_DEPTH - 1) ? IDLE : SW_RD;
          sw_idx <= sw_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tagged_update_sched.sv
// tb_tagged_update_sched: directed and random checks of tagged_update_sched against a phase-level sweep model
module tb_tagged_update_sched;
  localparam int D = 8;
  localparam int AGE = 4;
  localparam int IW = 3;
  localparam int TW = 8;
  localparam int CW = 3;
  localparam int UW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tagged_update_sched_if #(.IW(IW), .TAG_W(TW), .CTR_W(CW), .USEFUL_W(UW)) bus ();
  tagged_update_sched #(
    .PHT_DEPTH(D), .PHT_TAG_WIDTH(TW), .PHT_CTR_WIDTH(CW), .PHT_USEFUL_WIDTH(UW), .AGE_PERIOD(AGE)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [TW-1:0] mem_tag [D];
  logic [CW-1:0] mem_ctr [D];
  logic [UW-1:0] mem_use [D];
  logic          ld_en = 1'b0;
  logic [IW-1:0] ld_idx;
  logic [TW-1:0] ld_tag;
  logic [CW-1:0] ld_ctr;
  logic [UW-1:0] ld_use;
  // table model: read data one cycle after the request, a same-cycle write is forwarded to the read
  always @(posedge clk) begin
    if (bus.rd_req_o) begin
      if (bus.wr_valid_o && bus.wr_index_o == bus.rd_index_o) begin
        bus.rd_tag_i <= bus.wr_tag_o;
        bus.rd_ctr_i <= bus.wr_ctr_o;
        bus.rd_useful_i <= bus.wr_useful_o;
      end else begin
        bus.rd_tag_i <= mem_tag[bus.rd_index_o];
        bus.rd_ctr_i <= mem_ctr[bus.rd_index_o];
        bus.rd_useful_i <= mem_use[bus.rd_index_o];
      end
    end
    if (bus.wr_valid_o) begin
      mem_tag[bus.wr_index_o] <= bus.wr_tag_o;
      mem_ctr[bus.wr_index_o] <= bus.wr_ctr_o;
      mem_use[bus.wr_index_o] <= bus.wr_useful_o;
    end else if (ld_en) begin
      mem_tag[ld_idx] <= ld_tag;
      mem_ctr[ld_idx] <= ld_ctr;
      mem_use[ld_idx] <= ld_use;
    end
  end
  int n_cmp = 0;
  int n_err = 0;
  // reference: table contents, sweep position/phase, drop status and the write expected on the port now
  int ref_tag [D];
  int ref_ctr [D];
  int ref_use [D];
  bit m_sw = 0;
  int m_pos = 0;
  int m_ph = 0;
  int m_age = 0;
  bit m_drop = 0;
  int h_tag, h_ctr, h_use;
  bit p_v = 0;
  int p_idx, p_tag, p_ctr, p_use;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit v, input int idx, input int tg, input int ct, input int us, input bit busy);
    bit n_v, hz, adv;
    int n_idx, n_tag, n_ctr, n_use;
    @(negedge clk);
    rst = 1'b0;
    bus.upd_valid_i = v;
    bus.upd_index_i = IW'(idx);
    bus.upd_tag_i = TW'(tg);
    bus.upd_ctr_i = CW'(ct);
    bus.upd_useful_i = UW'(us);
    bus.query_busy_i = busy;
    #1;
    chk("upd_ready", 32'(bus.upd_ready_o), 1);
    chk("sweep_active", 32'(bus.sweep_active_o), 32'(m_sw));
    chk("rd_req", 32'(bus.rd_req_o), 32'(m_sw && m_ph == 0 && !busy));
    if (m_sw && m_ph == 0) chk("rd_index", 32'(bus.rd_index_o), m_pos);
    chk("wr_valid", 32'(bus.wr_valid_o), 32'(p_v));
    if (p_v) begin
      chk("wr_index", 32'(bus.wr_index_o), p_idx);
      chk("wr_tag", 32'(bus.wr_tag_o), p_tag);
      chk("wr_ctr", 32'(bus.wr_ctr_o), p_ctr);
      chk("wr_useful", 32'(bus.wr_useful_o), p_use);
      ref_tag[p_idx] = p_tag;
      ref_ctr[p_idx] = p_ctr;
      ref_use[p_idx] = p_use;
    end
    n_v = 0;
    adv = 0;
    n_idx = 0; n_tag = 0; n_ctr = 0; n_use = 0;
    hz = v && m_sw && idx == m_pos && (m_ph != 0 || !busy);
    if (v) begin
      n_v = 1; n_idx = idx; n_tag = tg; n_ctr = ct; n_use = us;
    end
    if (!m_sw) begin
      if (v) begin
        m_age++;
        if (m_age == AGE) begin
          m_age = 0; m_sw = 1; m_pos = 0; m_ph = 0; m_drop = 0;
        end
      end
    end else if (m_ph == 0) begin
      if (!busy) begin
        h_tag = ref_tag[m_pos]; h_ctr = ref_ctr[m_pos]; h_use = ref_use[m_pos];
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      m_ph = 2;
    end else if (m_drop || h_use == 0) begin
      adv = 1;
    end else if (!v) begin
      n_v = 1; n_idx = m_pos; n_tag = h_tag; n_ctr = h_ctr; n_use = h_use - 1;
      adv = 1;
    end
    if (hz) m_drop = 1;
    if (adv) begin
      m_drop = 0;
      if (m_pos == D - 1) m_sw = 0;
      else begin
        m_pos++;
        m_ph = 0;
      end
    end
    p_v = n_v; p_idx = n_idx; p_tag = n_tag; p_ctr = n_ctr; p_use = n_use;
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.upd_valid_i = 1'b0;
    bus.query_busy_i = 1'b0;
    #1;
    chk("ready_in_rst", 32'(bus.upd_ready_o), 0);
    if (p_v) begin
      ref_tag[p_idx] = p_tag; ref_ctr[p_idx] = p_ctr; ref_use[p_idx] = p_use;
    end
    p_v = 0; m_sw = 0; m_age = 0; m_drop = 0; m_ph = 0; m_pos = 0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(bus.upd_ready_o), 0);
      chk("rst_wr_valid", 32'(bus.wr_valid_o), 0);
      chk("rst_sweep_active", 32'(bus.sweep_active_o), 0);
      chk("rst_rd_req", 32'(bus.rd_req_o), 0);
    end
  endtask
  task automatic load_tab(input int use_val);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      ld_en = 1'b1;
      ld_idx = IW'(i);
      ld_tag = TW'($urandom_range(255));
      ld_ctr = CW'($urandom_range(7));
      ld_use = UW'(use_val < 0 ? int'($urandom_range(3)) : use_val);
      ref_tag[i] = int'(ld_tag); ref_ctr[i] = int'(ld_ctr); ref_use[i] = int'(ld_use);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask
  task automatic trig(input int us);
    for (int k = 0; k < 4; k++)
      cyc(1, int'($urandom_range(D - 1)), int'($urandom_range(255)), int'($urandom_range(7)),
          us < 0 ? int'($urandom_range(3)) : us, 0);
  endtask
  task automatic run_idle(input int lim);
    for (int k = 0; k < lim && m_sw; k++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sweep_done", 32'(bus.sweep_active_o), 0);
  endtask
  task automatic tab_cmp(input string tag);
    for (int i = 0; i < D; i++) begin
      chk({tag, "_tag"}, 32'(mem_tag[i]), ref_tag[i]);
      chk({tag, "_ctr"}, 32'(mem_ctr[i]), ref_ctr[i]);
      chk({tag, "_useful"}, 32'(mem_use[i]), ref_use[i]);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.upd_valid_i = 1'b0;
    bus.upd_index_i = '0;
    bus.upd_tag_i = '0;
    bus.upd_ctr_i = '0;
    bus.upd_useful_i = '0;
    bus.query_busy_i = 1'b0;
    do_reset(3);
    load_tab(2);
    // single update in IDLE: one write next cycle with identical fields
    cyc(1, 5, 'h2A, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // full sweep over a table of useful=2 entries
    do_reset(2);
    load_tab(2);
    for (int k = 0; k < 4; k++) cyc(1, k, int'($urandom_range(255)), int'($urandom_range(7)), 2, 0);
    run_idle(200);
    for (int i = 0; i < D; i++) chk("aged_useful", 32'(mem_use[i]), 1);
    tab_cmp("sweep1");
    // frontend holds the read port for 10 cycles at the start of a sweep
    trig(-1);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 1);
    run_idle(200);
    tab_cmp("busy");
    // update hits the entry whose read is in flight
    cyc(0, 0, 0, 0, 0, 0);
    load_tab(3);
    trig(3);
    for (int k = 0; k < 100 && !(m_sw && m_pos == 3 && m_ph == 1); k++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 3, 'h5C, 6, 3, 0);
    run_idle(200);
    chk("hazard_tag3", 32'(mem_tag[3]), 'h5C);
    chk("hazard_useful3", 32'(mem_use[3]), 3);
    chk("after_hazard_useful4", 32'(mem_use[4]), 32'(ref_use[4]));
    tab_cmp("hazard");
    // dense update traffic defers sweep writes; useful=0 entries are skipped
    cyc(0, 0, 0, 0, 0, 0);
    load_tab(-1);
    trig(-1);
    for (int k = 0; k < 80; k++)
      cyc($urandom_range(3) != 0, int'($urandom_range(D - 1)), int'($urandom_range(255)),
          int'($urandom_range(7)), int'($urandom_range(3)), $urandom_range(3) == 0);
    run_idle(200);
    tab_cmp("dense");
    // reset in the middle of a sweep, next sweep restarts at index 0
    trig(-1);
    for (int k = 0; k < 100 && !(m_sw && m_pos == 6); k++) cyc(0, 0, 0, 0, 0, 0);
    do_reset(2);
    trig(-1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("restart_active", 32'(bus.sweep_active_o), 1);
    chk("restart_index", 32'(bus.rd_index_o), 0);
    run_idle(200);
    tab_cmp("restart");
    // random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(149) == 0) do_reset(2);
      cyc($urandom_range(1) == 1, int'($urandom_range(D - 1)), int'($urandom_range(255)),
          int'($urandom_range(7)), int'($urandom_range(3)), $urandom_range(2) == 0);
    end
    run_idle(200);
    tab_cmp("random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
